mouse_cursor_tracker: RTL

//  Downstream consumer of ps2_mouse. On dav it reads the three ps2_mouse registers (status, X, Y)

---
 rtl/mouse_cursor_tracker_pkg.sv | 28 ++
 rtl/mouse_axis_accum.sv | 51 +++++
 rtl/mouse_cursor_tracker.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mouse_cursor_tracker_pkg.sv
// Shared definitions for the ps2_mouse read port: register map, status-byte layout, FSM encodings.
package mouse_cursor_tracker_pkg;

  localparam logic [1:0] ADDR_STAT = 2'b00;
  localparam logic [1:0] ADDR_X    = 2'b01;
  localparam logic [1:0] ADDR_Y    = 2'b10;

  localparam int unsigned BIT_L     = 0;
  localparam int unsigned BIT_R     = 1;
  localparam int unsigned BIT_M     = 2;
  localparam int unsigned BIT_XSIGN = 4;
  localparam int unsigned BIT_YSIGN = 5;
  localparam int unsigned BIT_XOVF  = 6;
  localparam int unsigned BIT_YOVF  = 7;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRdStat  = 3'd1;
  localparam logic [2:0] StRdX     = 3'd2;
  localparam logic [2:0] StRdY     = 3'd3;
  localparam logic [2:0] StUpdate  = 3'd4;
  localparam logic [2:0] StWaitClr = 3'd5;

  // 9-bit PS/2 delta {sign, byte} widened to the 12-bit accumulation width.
  function automatic logic [11:0] sext_delta(input logic sign, input logic [7:0] mag);
    return {{4{sign}}, mag};
  endfunction

endpackage

// File: rtl/mouse_axis_accum.sv
// One clamped cursor axis: adds (or subtracts) a scaled PS/2 delta and saturates to 0..MAX.
module mouse_axis_accum
  import mouse_cursor_tracker_pkg::*;
#(
  parameter int MAX         = 639,
  parameter int INIT        = 320,
  parameter int SCALE_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sign,
  input  logic [7:0] mag,
  input  logic       ovf,
  input  logic       invert,
  input  logic       load,
  output logic [9:0] pos,
  output logic [9:0] pos_next
);

  logic [9:0]        pos_q, pos_d;
  logic signed [11:0] delta;
  logic signed [11:0] sum;

  always_comb begin
    delta = $signed(sext_delta(sign, mag)) >>> SCALE_SHIFT;
    sum   = $signed({2'b00, pos_q});
    // An overflowed axis keeps its position; the packet still counts for buttons.
    if (!ovf) begin
      sum = invert ? (sum - delta) : (sum + delta);
    end
    if (sum < 0) begin
      pos_next = 10'd0;
    end else if (sum > MAX) begin
      pos_next = 10'(MAX);
    end else begin
      pos_next = sum[9:0];
    end
    pos_d = load ? pos_next : pos_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q <= 10'(INIT);
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/mouse_cursor_tracker.sv
// Reads status/X/Y from ps2_mouse on each dav and tracks a clamped screen cursor plus buttons.
module mouse_cursor_tracker
  import mouse_cursor_tracker_pkg::*;
#(
  parameter int unsigned X_MAX       = 639,
  parameter int unsigned Y_MAX       = 479,
  parameter int unsigned X_INIT      = 320,
  parameter int unsigned Y_INIT      = 240,
  parameter int unsigned SCALE_SHIFT = 0,
  parameter int unsigned CLR_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dav,
  input  logic [7:0] data,
  output logic       io_cs,
  output logic [1:0] addr,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic [2:0] buttons,
  output logic       moved,
  output logic       timeout_err
);

  localparam int unsigned CntW = $clog2(CLR_TIMEOUT + 1);

  logic [2:0]      state_q, state_d;
  logic            io_cs_q, io_cs_d;
  logic [1:0]      addr_q, addr_d;
  logic [7:0]      stat_q, stat_d, dx_q, dx_d, dy_q, dy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tout_q, tout_d;
  logic [2:0]      buttons_q, buttons_d;
  logic            moved_q, moved_d;
  logic            load;
  logic [9:0]      x_next, y_next;

  mouse_axis_accum #(
    .MAX        (int'(X_MAX)),
    .INIT       (int'(X_INIT)),
    .SCALE_SHIFT(int'(SCALE_SHIFT))
  ) u_x (
    .clk     (clk),
    .rst     (rst),
    .sign    (stat_q[BIT_XSIGN]),
    .mag     (dx_q),
    .ovf     (stat_q[BIT_XOVF]),
    .invert  (1'b0),
    .load    (load),
    .pos     (cursor_x),
    .pos_next(x_next)
  );

  // PS/2 +Y is up while screen Y grows downward, hence the inverted axis.
  mouse_axis_accum #(
    .MAX        (int'(Y_MAX)),
    .INIT       (int'(Y_INIT)),
    .SCALE_SHIFT(int'(SCALE_SHIFT))
  ) u_y (
    .clk     (clk),
    .rst     (rst),
    .sign    (stat_q[BIT_YSIGN]),
    .mag     (dy_q),
    .ovf     (stat_q[BIT_YOVF]),
    .invert  (1'b1),
    .load    (load),
    .pos     (cursor_y),
    .pos_next(y_next)
  );

  always_comb begin
    state_d   = state_q;
    io_cs_d   = 1'b0;
    addr_d    = addr_q;
    stat_d    = stat_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    cnt_d     = cnt_q;
    tout_d    = tout_q;
    buttons_d = buttons_q;
    moved_d   = 1'b0;
    load      = 1'b0;
    case (state_q)
      StIdle: begin
        if (dav) begin
          state_d = StRdStat;
          io_cs_d = 1'b1;
          addr_d  = ADDR_STAT;
        end
      end
      StRdStat: begin
        stat_d  = data;
        state_d = StRdX;
        io_cs_d = 1'b1;
        addr_d  = ADDR_X;
      end
      StRdX: begin
        dx_d    = data;
        state_d = StRdY;
        io_cs_d = 1'b1;
        addr_d  = ADDR_Y;
      end
      StRdY: begin
        dy_d    = data;
        state_d = StUpdate;
      end
      StUpdate: begin
        load      = 1'b1;
        buttons_d = stat_q[BIT_M:BIT_L];
        moved_d   = (x_next != cursor_x) || (y_next != cursor_y) ||
                    (stat_q[BIT_M:BIT_L] != buttons_q);
        cnt_d     = '0;
        state_d   = StWaitClr;
      end
      StWaitClr: begin
        if (!dav) begin
          state_d = StIdle;
        end else if (cnt_q == CntW'(CLR_TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      io_cs_q   <= 1'b0;
      addr_q    <= ADDR_STAT;
      stat_q    <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      cnt_q     <= '0;
      tout_q    <= 1'b0;
      buttons_q <= '0;
      moved_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      io_cs_q   <= io_cs_d;
      addr_q    <= addr_d;
      stat_q    <= stat_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      cnt_q     <= cnt_d;
      tout_q    <= tout_d;
      buttons_q <= buttons_d;
      moved_q   <= moved_d;
    end
  end

  assign io_cs       = io_cs_q;
  assign addr        = addr_q;
  assign buttons     = buttons_q;
  assign moved       = moved_q;
  assign timeout_err = tout_q;

endmodule
